// File: rtl/quantizer_pkg.sv
// Shared types and constants for the dynamic block quantizer.
// Holds the control-state encoding and rounding/saturation helpers.
package quantizer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MAX,
      S_DIV,
      S_QUANT,
      S_OUT
   } state_t;

   function automatic logic [63:0] round_half(input int frac);
      return (frac > 0) ? (64'd1 << (frac - 1)) : 64'd0;
   endfunction

   function automatic logic [63:0] sat_max(input int ow);
      return (64'd1 << (ow - 1)) - 64'd1;
   endfunction

endpackage

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Quotient is valid the cycle after done is asserted.
module seq_restoring_divider #(
   parameter int WIDTH     = 32,
   parameter int DIV_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     dividend,
   input  logic [DIV_WIDTH-1:0] divisor,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     quotient
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0]     q_r;
   logic [DIV_WIDTH-1:0] rem_r;
   logic [DIV_WIDTH-1:0] dvs_r;
   logic [CW-1:0]        cnt_r;
   logic [DIV_WIDTH:0]   shifted;
   logic [DIV_WIDTH-1:0] diff;
   logic                 ge;

   // q_r shifts dividend bits out the top while quotient bits enter below
   always_comb begin
      shifted = {rem_r, q_r[WIDTH-1]};
      ge      = shifted >= {1'b0, dvs_r};
      diff    = shifted[DIV_WIDTH-1:0] - dvs_r;
   end

   assign busy     = cnt_r != '0;
   assign done     = cnt_r == CW'(1);
   assign quotient = q_r;

   always_ff @(posedge clk) begin
      if (rst) begin
         q_r   <= '0;
         rem_r <= '0;
         dvs_r <= '0;
         cnt_r <= '0;
      end else if (start) begin
         q_r   <= dividend;
         rem_r <= '0;
         dvs_r <= divisor;
         cnt_r <= CW'(WIDTH);
      end else if (busy) begin
         q_r   <= {q_r[WIDTH-2:0], ge};
         rem_r <= ge ? diff : shifted[DIV_WIDTH-1:0];
         cnt_r <= cnt_r - CW'(1);
      end
   end

endmodule

// File: rtl/dynamic_block_quantizer.sv
// Block absmax quantizer: absmax, iterative scale divide, then
// per-lane round-half-away and symmetric saturation to OUT_WIDTH.
module dynamic_block_quantizer
   import quantizer_pkg::*;
#(
   parameter int IN_WIDTH         = 16,
   parameter int IN_SIZE          = 4,
   parameter int IN_PARALLELISM   = 1,
   parameter int OUT_WIDTH        = 8,
   parameter int SCALE_WIDTH      = 32,
   parameter int SCALE_FRAC_WIDTH = 16,
   localparam int N = IN_SIZE * IN_PARALLELISM
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [N-1:0][IN_WIDTH-1:0]         data_in,
   input  logic                               data_in_valid,
   output logic                               data_in_ready,
   output logic [N-1:0][OUT_WIDTH-1:0]        data_out,
   output logic [SCALE_WIDTH-1:0]             scale_out,
   output logic [IN_WIDTH-1:0]                max_abs_out,
   output logic                               zero_block,
   output logic                               data_out_valid,
   input  logic                               data_out_ready
);

   localparam int PW = IN_WIDTH + SCALE_WIDTH + 1;
   localparam int LV = $clog2(N);
   localparam int P  = 1 << LV;
   localparam logic [PW-1:0] RH  = PW'(round_half(SCALE_FRAC_WIDTH));
   localparam logic [PW-1:0] SAT = PW'(sat_max(OUT_WIDTH));
   localparam logic [SCALE_WIDTH-1:0] DIVIDEND =
      SCALE_WIDTH'(sat_max(OUT_WIDTH) << SCALE_FRAC_WIDTH);

   state_t state, state_n;

   logic [N-1:0][IN_WIDTH-1:0]  blk_r;
   logic [N-1:0][OUT_WIDTH-1:0] qv;
   logic [IN_WIDTH-1:0]         max_q;
   logic                        zero_q;
   logic [IN_WIDTH-1:0]         tree [2*P-1];
   logic [IN_WIDTH-1:0]         root;
   logic [SCALE_WIDTH-1:0]      div_q;
   logic [SCALE_WIDTH-1:0]      scale_use;
   logic                        div_start;
   logic                        div_busy;
   logic                        div_done;

   // Padded binary max tree over element magnitudes
   for (genvar i = 0; i < P; i++) begin : g_leaf
      if (i < N) begin : g_real
         assign tree[P-1+i] = blk_r[i][IN_WIDTH-1] ?
                              ('0 - blk_r[i]) : blk_r[i];
      end else begin : g_pad
         assign tree[P-1+i] = '0;
      end
   end

   for (genvar k = 0; k < P - 1; k++) begin : g_node
      assign tree[k] = (tree[2*k+1] >= tree[2*k+2]) ?
                       tree[2*k+1] : tree[2*k+2];
   end

   assign root      = tree[0];
   assign div_start = (state == S_MAX) && (root != '0);
   assign scale_use = zero_q ? '0 : div_q;

   seq_restoring_divider #(
      .WIDTH     (SCALE_WIDTH),
      .DIV_WIDTH (IN_WIDTH)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (DIVIDEND),
      .divisor  (root),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_q)
   );

   for (genvar i = 0; i < N; i++) begin : g_lane
      logic signed [PW-1:0] prod;
      logic [PW-1:0]        mag;
      logic [PW-1:0]        rnd;
      logic [OUT_WIDTH-1:0] lv;
      logic [OUT_WIDTH-1:0] res;
      always_comb begin
         prod = PW'($signed(blk_r[i])) *
                PW'($signed({1'b0, scale_use}));
         mag  = prod[PW-1] ? PW'(-prod) : PW'(prod);
         rnd  = (mag + RH) >> SCALE_FRAC_WIDTH;
         lv   = (rnd > SAT) ? SAT[OUT_WIDTH-1:0] : rnd[OUT_WIDTH-1:0];
         res  = prod[PW-1] ? ('0 - lv) : lv;
      end
      assign qv[i] = res;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n        = state;
      data_in_ready  = 1'b0;
      data_out_valid = 1'b0;
      unique case (state)
         S_IDLE: begin
            data_in_ready = 1'b1;
            if (data_in_valid) state_n = S_MAX;
         end
         S_MAX:   state_n = (root == '0) ? S_QUANT : S_DIV;
         S_DIV:   if (div_done || !div_busy) state_n = S_QUANT;
         S_QUANT: state_n = S_OUT;
         S_OUT: begin
            data_out_valid = 1'b1;
            if (data_out_ready) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         blk_r       <= '0;
         max_q       <= '0;
         zero_q      <= 1'b0;
         data_out    <= '0;
         scale_out   <= '0;
         max_abs_out <= '0;
         zero_block  <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: if (data_in_valid) blk_r <= data_in;
            S_MAX: begin
               max_q  <= root;
               zero_q <= root == '0;
            end
            S_QUANT: begin
               data_out    <= qv;
               scale_out   <= scale_use;
               max_abs_out <= max_q;
               zero_block  <= zero_q;
            end
            default: ;
         endcase
      end
   end

endmodule
